// File: rtl/csr_access_unit.sv
// csr_access_unit
//
// Execute-stage sequencer for Zicsr instructions (CSRRW/CSRRS/CSRRC and the
// immediate forms). It issues a read strobe and/or a write strobe to the csr
// block and does the read-modify-write locally, so the csr block always sees a
// full replacement value (write_function is fixed to RW). It returns the old
// CSR value, or an illegal-instruction exception, over a valid/ready handshake,
// and pulses instr_retired when a CSR instruction retires.
//
// Ports:
//   clock, reset              - clock; asynchronous active-low reset
//   req_*                     - decoded CSR instruction in (valid/ready)
//   flush                     - pipeline kill
//   csr_addr, read_csr,
//   read_value, write_csr,
//   write_function,
//   write_value,
//   illegal_instr_exception   - access port of the csr block (combinational)
//   resp_*                    - result to the pipeline (valid/ready)
//   instr_retired             - one-cycle pulse per retired CSR instruction

module csr_access_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_csr_addr,
    input  logic [4:0]  req_rs1_idx,
    input  logic [31:0] req_rs1_value,
    input  logic [4:0]  req_rd_idx,
    input  logic        flush,
    output logic [11:0] csr_addr,
    output logic        read_csr,
    input  logic [31:0] read_value,
    output logic        write_csr,
    output logic [1:0]  write_function,
    output logic [31:0] write_value,
    input  logic        illegal_instr_exception,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [4:0]  resp_rd_idx,
    output logic [31:0] resp_rd_value,
    output logic        resp_rd_write,
    output logic        resp_exception,
    output logic        instr_retired
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rs1_idx_q, rs1_idx_d;
    logic [31:0] rs1_value_q, rs1_value_d;
    logic [4:0]  rd_idx_q, rd_idx_d;
    logic [31:0] old_q, old_d;
    logic        exc_q, exc_d;
    logic        did_read_q, did_read_d;

    logic        accept;
    logic        req_do_read;
    logic        lat_do_write;
    logic [31:0] src;
    logic [31:0] rmw_value;

    assign accept = req_valid && req_ready;

    // CSRRW/CSRRWI to x0 skips the read entirely (no read side effects).
    assign req_do_read = !(req_funct3[1:0] == 2'b01 && req_rd_idx == 5'd0);

    // Set/clear forms with a zero source are pure reads.
    assign lat_do_write = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);

    assign src = funct3_q[2] ? {27'b0, rs1_idx_q} : rs1_value_q;

    always_comb begin
        rmw_value = '0;
        case (funct3_q[1:0])
            2'b01:   rmw_value = src;
            2'b10:   rmw_value = old_q | src;
            2'b11:   rmw_value = old_q & ~src;
            default: rmw_value = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        rs1_idx_d   = rs1_idx_q;
        rs1_value_d = rs1_value_q;
        rd_idx_d    = rd_idx_q;
        old_d       = old_q;
        exc_d       = exc_q;
        did_read_d  = did_read_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d      = req_csr_addr;
                    funct3_d    = req_funct3;
                    rs1_idx_d   = req_rs1_idx;
                    rs1_value_d = req_rs1_value;
                    rd_idx_d    = req_rd_idx;
                    old_d       = '0;
                    exc_d       = 1'b0;
                    did_read_d  = 1'b0;
                    if (req_funct3[1:0] == 2'b00) begin
                        exc_d   = 1'b1;
                        state_d = StResp;
                    end else if (req_do_read) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StRead: begin
                old_d      = read_value;
                exc_d      = illegal_instr_exception;
                did_read_d = 1'b1;
                if (flush) begin
                    state_d = StIdle;
                end else if (illegal_instr_exception) begin
                    state_d = StResp;
                end else if (lat_do_write) begin
                    state_d = StWrite;
                end else begin
                    state_d = StResp;
                end
            end
            StWrite: begin
                // The write strobe has already been presented this cycle, so a
                // flush only suppresses the response.
                exc_d   = illegal_instr_exception;
                state_d = flush ? StIdle : StResp;
            end
            StResp: begin
                if (flush || resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            funct3_q    <= '0;
            rs1_idx_q   <= '0;
            rs1_value_q <= '0;
            rd_idx_q    <= '0;
            old_q       <= '0;
            exc_q       <= 1'b0;
            did_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            rs1_idx_q   <= rs1_idx_d;
            rs1_value_q <= rs1_value_d;
            rd_idx_q    <= rd_idx_d;
            old_q       <= old_d;
            exc_q       <= exc_d;
            did_read_q  <= did_read_d;
        end
    end

    // All csr-side outputs decode from registered state only.
    assign req_ready      = (state_q == StIdle) && !flush;
    assign read_csr       = (state_q == StRead);
    assign write_csr      = (state_q == StWrite);
    assign csr_addr       = (read_csr || write_csr) ? addr_q : 12'h000;
    assign write_function = 2'b01;
    assign write_value    = write_csr ? rmw_value : 32'h0;

    assign resp_valid     = (state_q == StResp) && !flush;
    assign resp_rd_idx    = rd_idx_q;
    assign resp_rd_value  = old_q;
    assign resp_rd_write  = resp_valid && did_read_q && !exc_q && (rd_idx_q != 5'd0);
    assign resp_exception = (state_q == StResp) && exc_q;
    assign instr_retired  = resp_valid && resp_ready && !exc_q;

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = '0;
    logic [11:0] req_csr_addr = '0;
    logic [4:0]  req_rs1_idx = '0;
    logic [31:0] req_rs1_value = '0;
    logic [4:0]  req_rd_idx = '0;
    logic        flush = 1'b0;
    logic [11:0] csr_addr;
    logic        read_csr;
    logic [31:0] read_value;
    logic        write_csr;
    logic [1:0]  write_function;
    logic [31:0] write_value;
    logic        illegal_instr_exception;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [4:0]  resp_rd_idx;
    logic [31:0] resp_rd_value;
    logic        resp_rd_write;
    logic        resp_exception;
    logic        instr_retired;

    csr_access_unit dut (
        .clock                  (clock),
        .reset                  (reset),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_funct3             (req_funct3),
        .req_csr_addr           (req_csr_addr),
        .req_rs1_idx            (req_rs1_idx),
        .req_rs1_value          (req_rs1_value),
        .req_rd_idx             (req_rd_idx),
        .flush                  (flush),
        .csr_addr               (csr_addr),
        .read_csr               (read_csr),
        .read_value             (read_value),
        .write_csr              (write_csr),
        .write_function         (write_function),
        .write_value            (write_value),
        .illegal_instr_exception(illegal_instr_exception),
        .resp_valid             (resp_valid),
        .resp_ready             (resp_ready),
        .resp_rd_idx            (resp_rd_idx),
        .resp_rd_value          (resp_rd_value),
        .resp_rd_write          (resp_rd_write),
        .resp_exception         (resp_exception),
        .instr_retired          (instr_retired)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Output vector compared against its reset value.
    logic [88:0] out_vec;
    assign out_vec = {resp_valid, read_csr, write_csr, csr_addr, write_value, write_function,
                      resp_rd_value, resp_rd_idx, resp_rd_write, resp_exception, instr_retired};
    logic [88:0] reset_vec;
    assign reset_vec = {3'b000, 12'h000, 32'h0, 2'b01, 32'h0, 5'h0, 3'b000};

    // CSR block model: 0x340 and 0x300 read/write, 0xC00 read-only cycle counter
    // fixed at 0x123, everything else illegal.
    logic [31:0] m340, m300;
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_val = '0;

    always @(posedge clock) begin
        if (pl_en) begin
            if (pl_addr == 12'h340) m340 <= pl_val;
            else m300 <= pl_val;
        end else if (write_csr && !illegal_instr_exception) begin
            if (csr_addr == 12'h340) m340 <= write_value;
            else if (csr_addr == 12'h300) m300 <= write_value;
        end
    end

    always_comb begin
        read_value = 32'h0;
        illegal_instr_exception = 1'b0;
        if (read_csr || write_csr) begin
            case (csr_addr)
                12'h340: read_value = m340;
                12'h300: read_value = m300;
                12'hC00: begin
                    read_value = 32'h123;
                    illegal_instr_exception = write_csr;
                end
                default: illegal_instr_exception = 1'b1;
            endcase
        end
    end

    // Observations of one transaction.
    logic [11:0] cur_addr;
    int          obs_reads, obs_writes, obs_rcyc, obs_wcyc, obs_lat, obs_early, obs_badaddr;
    logic [31:0] obs_wval, obs_rd_value;
    logic [1:0]  obs_wfunc;
    logic [4:0]  obs_rd_idx;
    logic        obs_rd_write, obs_exc, obs_retire;

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_val = v;
        @(posedge clock);
        #1 pl_en = 1'b0;
    endtask

    task automatic accept(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1i,
                          input logic [31:0] rs1v, input logic [4:0] rd);
        int n;
        n = 0;
        @(negedge clock);
        req_valid = 1'b1; req_funct3 = f3; req_csr_addr = a;
        req_rs1_idx = rs1i; req_rs1_value = rs1v; req_rd_idx = rd;
        cur_addr = a;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready got 0 expected 1");
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    // Walks cycles 1.. after the accept edge until resp_valid, at negedges.
    task automatic collect();
        int  c;
        bit  done;
        c = 0; done = 0;
        obs_reads = 0; obs_writes = 0; obs_rcyc = 0; obs_wcyc = 0; obs_lat = 0;
        obs_early = 0; obs_badaddr = 0; obs_wval = 32'h0; obs_wfunc = 2'b01;
        while (!done && c < 8) begin
            @(negedge clock);
            c++;
            if (instr_retired) obs_early++;
            if (resp_valid) begin
                obs_lat = c; obs_rd_value = resp_rd_value; obs_rd_idx = resp_rd_idx;
                obs_rd_write = resp_rd_write; obs_exc = resp_exception;
                done = 1;
            end else begin
                if (read_csr) begin
                    obs_reads++; obs_rcyc = c;
                    if (csr_addr !== cur_addr) obs_badaddr++;
                end
                if (write_csr) begin
                    obs_writes++; obs_wcyc = c; obs_wval = write_value; obs_wfunc = write_function;
                    if (csr_addr !== cur_addr) obs_badaddr++;
                end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL resp_timeout: resp_valid got 0 expected 1 within 8 cycles");
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        #1 obs_retire = instr_retired;
        @(posedge clock);
        #1 resp_ready = 1'b0;
    endtask

    task automatic run(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1i,
                       input logic [31:0] rs1v, input logic [4:0] rd);
        accept(f3, a, rs1i, rs1v, rd);
        collect();
        finish_resp();
    endtask

    // Instruction-level reference: what a CSR instruction must do, by its rules.
    task automatic ref_model(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1i,
                             input logic [31:0] rs1v, input logic [4:0] rd,
                             output int e_reads, output int e_writes, output int e_lat,
                             output logic e_exc, output logic e_rdw,
                             output logic [31:0] e_old, output logic [31:0] e_new);
        logic        known, ro;
        logic [31:0] cur, src;
        logic [1:0]  op;
        op    = f3[1:0];
        known = (a == 12'h340) || (a == 12'h300) || (a == 12'hC00);
        ro    = (a == 12'hC00);
        cur   = (a == 12'h340) ? m340 : (a == 12'h300) ? m300 : (a == 12'hC00) ? 32'h123 : 32'h0;
        src   = f3[2] ? {27'b0, rs1i} : rs1v;
        case (op)
            2'b01:   e_new = src;
            2'b10:   e_new = cur | src;
            2'b11:   e_new = cur & ~src;
            default: e_new = cur;
        endcase
        e_old = cur; e_reads = 0; e_writes = 0; e_exc = 1'b0;
        if (op == 2'b00) begin
            e_exc = 1'b1;
        end else begin
            if (!(op == 2'b01 && rd == 5'd0)) begin
                e_reads = 1;
                if (!known) e_exc = 1'b1;
            end
            if (!e_exc && (op == 2'b01 || rs1i != 5'd0)) begin
                e_writes = 1;
                if (!known || ro) e_exc = 1'b1;
            end
        end
        e_lat = 1 + e_reads + e_writes;
        e_rdw = (e_reads == 1) && !e_exc && (rd != 5'd0);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (out_vec !== reset_vec) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", out_vec, reset_vec);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_csrrs_cycle();
        run(3'b010, 12'hC00, 5'd0, 32'hAAAA_5555, 5'd5);
        checks++; if (obs_reads !== 1 || obs_rcyc !== 1) begin errors++;
            $display("FAIL rs_read: reads %0d at %0d expected 1 at 1", obs_reads, obs_rcyc); end
        checks++; if (obs_writes !== 0) begin errors++;
            $display("FAIL rs_nowrite: writes got %0d expected 0", obs_writes); end
        checks++; if (obs_lat !== 2) begin errors++;
            $display("FAIL rs_latency: got %0d expected 2", obs_lat); end
        checks++; if (obs_rd_value !== 32'h123) begin errors++;
            $display("FAIL rs_rd_value: got %h expected 00000123", obs_rd_value); end
        checks++; if ({obs_rd_write, obs_exc, obs_rd_idx} !== {1'b1, 1'b0, 5'd5}) begin errors++;
            $display("FAIL rs_resp: got wr=%b exc=%b rd=%0d expected 1 0 5",
                     obs_rd_write, obs_exc, obs_rd_idx); end
        checks++; if (obs_retire !== 1'b1 || obs_early !== 0) begin errors++;
            $display("FAIL rs_retire: got %b early %0d expected 1 0", obs_retire, obs_early); end
    endtask

    task automatic test_csrrci();
        preload(12'h340, 32'hFFFF_00FF);
        run(3'b111, 12'h340, 5'h0F, $urandom, 5'd7);
        checks++; if (obs_wcyc !== 2 || obs_wval !== 32'hFFFF_00F0) begin errors++;
            $display("FAIL rci_write: got %h at %0d expected ffff00f0 at 2", obs_wval, obs_wcyc); end
        checks++; if (obs_rd_value !== 32'hFFFF_00FF) begin errors++;
            $display("FAIL rci_rd_value: got %h expected ffff00ff", obs_rd_value); end
        checks++; if (obs_lat !== 3) begin errors++;
            $display("FAIL rci_latency: got %0d expected 3", obs_lat); end
        checks++; if (obs_retire !== 1'b1 || obs_early !== 0) begin errors++;
            $display("FAIL rci_retire: got %b early %0d expected 1 0", obs_retire, obs_early); end
        checks++; if (m340 !== 32'hFFFF_00F0) begin errors++;
            $display("FAIL rci_stored: got %h expected ffff00f0", m340); end
    endtask

    task automatic test_csrrw_x0();
        run(3'b001, 12'h340, 5'd3, 32'hDEAD_BEEF, 5'd0);
        checks++; if (obs_reads !== 0) begin errors++;
            $display("FAIL rw0_noread: reads got %0d expected 0", obs_reads); end
        checks++; if (obs_wcyc !== 1 || obs_wval !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL rw0_write: got %h at %0d expected deadbeef at 1", obs_wval, obs_wcyc); end
        checks++; if (obs_lat !== 2 || obs_rd_write !== 1'b0) begin errors++;
            $display("FAIL rw0_resp: lat %0d wr %b expected 2 0", obs_lat, obs_rd_write); end
        checks++; if (m340 !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL rw0_stored: got %h expected deadbeef", m340); end
    endtask

    task automatic test_ro_write();
        run(3'b001, 12'hC00, 5'd2, 32'h0000_0055, 5'd1);
        checks++; if (obs_reads !== 1 || obs_writes !== 1 || obs_lat !== 3) begin errors++;
            $display("FAIL ro_seq: reads %0d writes %0d lat %0d expected 1 1 3",
                     obs_reads, obs_writes, obs_lat); end
        checks++; if ({obs_exc, obs_rd_write, obs_retire} !== 3'b100) begin errors++;
            $display("FAIL ro_exc: exc/wr/ret got %b%b%b expected 100",
                     obs_exc, obs_rd_write, obs_retire); end
    endtask

    task automatic test_unknown_and_invalid();
        run(3'b010, 12'h7FF, 5'd3, 32'h1, 5'd4);
        checks++; if (obs_reads !== 1 || obs_writes !== 0 || obs_lat !== 2) begin errors++;
            $display("FAIL unk_seq: reads %0d writes %0d lat %0d expected 1 0 2",
                     obs_reads, obs_writes, obs_lat); end
        checks++; if ({obs_exc, obs_retire} !== 2'b10) begin errors++;
            $display("FAIL unk_exc: exc/ret got %b%b expected 10", obs_exc, obs_retire); end
        run(3'b100, 12'h340, 5'd1, 32'h1, 5'd1);
        checks++; if (obs_reads !== 0 || obs_writes !== 0 || obs_lat !== 1) begin errors++;
            $display("FAIL bad_f3_seq: reads %0d writes %0d lat %0d expected 0 0 1",
                     obs_reads, obs_writes, obs_lat); end
        checks++; if ({obs_exc, obs_rd_write, obs_retire} !== 3'b100) begin errors++;
            $display("FAIL bad_f3_exc: exc/wr/ret got %b%b%b expected 100",
                     obs_exc, obs_rd_write, obs_retire); end
    endtask

    task automatic test_backpressure();
        accept(3'b010, 12'hC00, 5'd0, 32'h0, 5'd5);
        collect();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({resp_valid, resp_rd_value, resp_rd_idx, resp_rd_write, resp_exception,
                 req_ready, instr_retired} !== {1'b1, 32'h123, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold_%0d: got v=%b val=%h rd=%0d wr=%b exc=%b rdy=%b ret=%b expected 1 123 5 1 0 0 0",
                         i, resp_valid, resp_rd_value, resp_rd_idx, resp_rd_write,
                         resp_exception, req_ready, instr_retired);
            end
        end
        finish_resp();
        checks++; if (obs_retire !== 1'b1) begin errors++;
            $display("FAIL hold_retire: got %b expected 1", obs_retire); end
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++;
            $display("FAIL hold_ready_after: got %b expected 1", req_ready); end
    endtask

    task automatic test_flush();
        int bad;
        preload(12'h340, 32'h1111_1111);
        // Flush during READ.
        accept(3'b010, 12'h340, 5'd0, 32'h0, 5'd5);
        @(negedge clock);
        checks++; if (read_csr !== 1'b1) begin errors++;
            $display("FAIL flr_in_read: read_csr got %b expected 1", read_csr); end
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (i == 0 && req_ready !== 1'b1) bad++;
            if (resp_valid || instr_retired || read_csr || write_csr) bad++;
        end
        checks++; if (bad !== 0) begin errors++;
            $display("FAIL flush_read: got %0d bad cycles expected 0", bad); end
        // Flush during WRITE: write still lands, no response.
        accept(3'b001, 12'h340, 5'd2, 32'h2222_2222, 5'd0);
        @(negedge clock);
        checks++; if (write_csr !== 1'b1) begin errors++;
            $display("FAIL flw_in_write: write_csr got %b expected 1", write_csr); end
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        checks++; if ({req_ready, resp_valid, instr_retired} !== 3'b100) begin errors++;
            $display("FAIL flush_write: rdy/valid/ret got %b%b%b expected 100",
                     req_ready, resp_valid, instr_retired); end
        checks++; if (m340 !== 32'h2222_2222) begin errors++;
            $display("FAIL flush_write_landed: got %h expected 22222222", m340); end
    endtask

    task automatic test_reset_mid();
        preload(12'h340, 32'h0000_0033);
        accept(3'b001, 12'h340, 5'd2, 32'h0000_0044, 5'd0);
        @(negedge clock);
        checks++; if (write_csr !== 1'b1) begin errors++;
            $display("FAIL rst_in_write: write_csr got %b expected 1", write_csr); end
        #1 reset = 1'b0;
        #1;
        checks++; if (out_vec !== reset_vec) begin errors++;
            $display("FAIL rst_mid_outputs: got %h expected %h", out_vec, reset_vec); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1 || m340 !== 32'h0000_0033) begin errors++;
            $display("FAIL rst_mid_after: rdy %b m340 %h expected 1 00000033", req_ready, m340); end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [11:0] a;
        logic [4:0]  rs1i, rd;
        logic [31:0] rs1v, e_old, e_new, p340, p300, x340, x300;
        int          e_reads, e_writes, e_lat;
        logic        e_exc, e_rdw;
        for (int it = 0; it < 40; it++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: a = 12'h340;
                1: a = 12'h300;
                2: a = 12'hC00;
                default: a = 12'h7FF;
            endcase
            rs1i = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs1v = $urandom;
            p340 = m340; p300 = m300;
            ref_model(f3, a, rs1i, rs1v, rd, e_reads, e_writes, e_lat, e_exc, e_rdw, e_old, e_new);
            run(f3, a, rs1i, rs1v, rd);
            x340 = (e_writes == 1 && !e_exc && a == 12'h340) ? e_new : p340;
            x300 = (e_writes == 1 && !e_exc && a == 12'h300) ? e_new : p300;
            checks++;
            if (obs_reads !== e_reads || obs_writes !== e_writes || obs_lat !== e_lat ||
                obs_badaddr !== 0) begin
                errors++;
                $display("FAIL rnd%0d_seq: r/w/lat/badaddr %0d %0d %0d %0d expected %0d %0d %0d 0",
                         it, obs_reads, obs_writes, obs_lat, obs_badaddr, e_reads, e_writes, e_lat);
            end
            checks++;
            if ({obs_exc, obs_rd_write, obs_retire, obs_rd_idx} !== {e_exc, e_rdw, !e_exc, rd} ||
                obs_early !== 0) begin
                errors++;
                $display("FAIL rnd%0d_resp: exc/wr/ret/rd %b %b %b %0d early %0d expected %b %b %b %0d 0",
                         it, obs_exc, obs_rd_write, obs_retire, obs_rd_idx, obs_early,
                         e_exc, e_rdw, !e_exc, rd);
            end
            if (e_writes == 1) begin
                checks++;
                if (obs_wval !== e_new || obs_wfunc !== 2'b01) begin
                    errors++;
                    $display("FAIL rnd%0d_wval: got %h func %b expected %h 01",
                             it, obs_wval, obs_wfunc, e_new);
                end
            end
            if (e_reads == 1 && a != 12'h7FF) begin
                checks++;
                if (obs_rd_value !== e_old) begin
                    errors++;
                    $display("FAIL rnd%0d_old: got %h expected %h", it, obs_rd_value, e_old);
                end
            end
            checks++;
            if (m340 !== x340 || m300 !== x300) begin
                errors++;
                $display("FAIL rnd%0d_store: got %h %h expected %h %h", it, m340, m300, x340, x300);
            end
        end
    endtask

    initial begin
        test_reset();
        preload(12'h300, 32'h0F0F_0F0F);
        preload(12'h340, 32'h0);
        test_csrrs_cycle();
        test_csrrci();
        test_csrrw_x0();
        test_ro_write();
        test_unknown_and_invalid();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Execute-stage sequencer that turns a decoded Zicsr instruction (CSRRW/CSRRS/CSRRC and their immediate forms) into read and write strobes on the `csr` block's access port. It performs the read-modify-write itself and always presents the `csr` block with a full replacement value. It returns the old CSR value for `rd`, or an illegal-instruction exception, to the pipeline over a valid/ready handshake. It also produces the `instr_retired` pulse that feeds the `csr` block's retired-instruction counter.

## Interface
- No parameters; widths fixed: XLEN 32 (`arch_reg`), CSR address 12 (`csr_addr_t`), write function 2 (`csr_write_func`).
- `clock` in 1: single clock domain; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. Asserting it forces all state to reset values immediately; release is synchronous to `clock`.
- `req_valid` in 1: decoded CSR instruction present.
- `req_ready` out 1: unit can accept a request. High only in IDLE.
- `req_funct3` in 3: instr[14:12].
- `req_csr_addr` in 12: instr[31:20].
- `req_rs1_idx` in 5: instr[19:15]; used as zero-extended uimm when `funct3[2]`=1.
- `req_rs1_value` in 32: rs1 operand.
- `req_rd_idx` in 5: destination register.
- `flush` in 1: pipeline kill.
- `csr_addr` out 12: address to the `csr` block.
- `read_csr` out 1: read strobe to the `csr` block.
- `read_value` in 32: data from the `csr` block, combinational.
- `write_csr` out 1: write strobe to the `csr` block.
- `write_function` out 2: always `2'b01` (RW). The unit does the RMW itself.
- `write_value` out 32: full replacement value.
- `illegal_instr_exception` in 1: from the `csr` block, combinational.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: pipeline accepts the result.
- `resp_rd_idx` out 5: destination register of the result.
- `resp_rd_value` out 32: old CSR value.
- `resp_rd_write` out 1: writeback enable. Set when `rd`≠0, the read was performed, and no exception occurred.
- `resp_exception` out 1: illegal instruction.
- `instr_retired` out 1: one-cycle pulse per retired CSR instruction.

## Operation
- FSM states: IDLE, READ, WRITE, RESP. The state is registered; all `csr`-side outputs decode from the registered state and the registered request fields.
- Request accept: `req_valid && req_ready` in IDLE latches the address, funct3, rs1_idx, rs1_value and rd_idx.
- Invalid funct3: if funct3[1:0]=00 the instruction is not a CSR op. Go to RESP with `resp_exception`=1 and issue no strobes.
- Read decision: `do_read` = !(funct3[1:0]==01 && rd==0). CSRRW/CSRRWI to x0 does not read.
- Write decision: `do_write` = (funct3[1:0]==01) || (src_sel≠0).
  - `src_sel` is rs1_idx for all forms, including the register forms with x0.
  - CSRRS/CSRRC with rs1=x0 or uimm=0 do not write.
- Transitions:
  - IDLE→READ if `do_read`, else IDLE→WRITE.
  - READ: `read_csr`=1. Capture `read_value` into old-value register and sample `illegal_instr_exception`.
    - Exception → RESP.
    - Else `do_write` → WRITE.
    - Else → RESP.
  - WRITE: `write_csr`=1. Sample `illegal_instr_exception` → RESP.
  - RESP: `resp_valid`=1, held stable until `resp_ready`; then → IDLE.
- Write value computation, with `src` = funct3[2] ? {27'b0, rs1_idx} : rs1_value:
  - RW: `src`.
  - RS: `old | src`.
  - RC: `old & ~src`.
- `csr_addr` is 0 in IDLE and RESP. `write_value` is 0 outside WRITE.
- `instr_retired`=1 in the cycle RESP handshakes with `resp_exception`=0.
- Flush:
  - In READ or RESP: return to IDLE, with no response and no retire.
  - In WRITE: the write completes (it is already a side effect), then go to IDLE with no response.
  - In IDLE: a same-cycle request is not accepted (`req_ready` is gated by !`flush`).
- Reset mid-operation: the FSM goes to IDLE and the outstanding request is dropped. No strobe may remain asserted while `reset` is low.

## Timing
- Reset values:
  - `req_ready`=1 once `reset` is released.
  - `resp_valid`=0, `read_csr`=0, `write_csr`=0, `csr_addr`=0, `write_value`=0, `write_function`=01.
  - `resp_rd_value`=0, `resp_rd_idx`=0, `resp_rd_write`=0, `resp_exception`=0, `instr_retired`=0.
- Latency from the accept edge (cycle 0) to the first `resp_valid` cycle:
  - Read+write: 3 (READ c1, WRITE c2, RESP c3).
  - Read-only or write-only: 2.
  - Invalid funct3: 1.
- Throughput: one instruction per 3–4 cycles. `req_ready` is low from the accept edge until the RESP handshake cycle has completed.
- `read_value` and `illegal_instr_exception` are sampled at the end of the single strobe cycle. The `csr` block must respond combinationally.
- RESP outputs are stable while `resp_valid && !resp_ready`.

## Test plan
- CSRRS x5, 0xC00 (cycle), rs1=x0, with the `csr` cycle counter at 0x0000_0123:
  - One READ cycle; `write_csr` never high.
  - `resp_rd_value`=0x123, `resp_rd_write`=1, `resp_valid` at cycle 2.
- Bench CSR model at 0x340 holding 0xFFFF_00FF; CSRRCI x7, 0x340, uimm=0x0F:
  - `write_value`=0xFFFF_00F0 at cycle 2.
  - `resp_rd_value`=0xFFFF_00FF.
  - `instr_retired` pulses once.
- CSRRW x0, 0x340, rs1_value=0xDEAD_BEEF:
  - No `read_csr`; WRITE at cycle 1 with value 0xDEAD_BEEF.
  - `resp_rd_write`=0 at cycle 2.
- CSRRW x1, 0xC00 (read-only counter; model asserts exception on write):
  - READ then WRITE; `resp_exception`=1, `resp_rd_write`=0, no retire.
- Unknown address 0x7FF read:
  - Exception at READ, no WRITE; RESP at cycle 2.
- Combined stress:
  - Hold `resp_ready` low for 3 cycles: RESP values stay frozen and `req_ready` stays 0.
  - `flush` in READ: IDLE next cycle, no response.
  - `reset` low during WRITE: all outputs reach reset values immediately.
